// File: rtl/io_port_unit_pkg.sv
// Shared definitions for the buffered processor I/O port: default width,
// error-flag bit positions and interrupt FSM state encodings.
package io_port_unit_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ERR_OUT_OVF = 0;
  localparam int ERR_IN_UNF  = 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PULSE      = 2'd1,
    ST_ARMED_WAIT = 2'd2
  } int_state_t;

endpackage

// File: rtl/io_port_unit_sync_fifo.sv
// First-word fall-through synchronous FIFO with registered full/empty flags.
// Push while full is only honoured together with a pop; pop while empty is ignored.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_nxt;

  assign w_pop  = pop && !r_empty;
  assign w_push = push && (!r_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is not reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

endmodule

// File: rtl/io_port_unit.sv
// Buffered I/O port between the core's OUT/IN instructions and external devices,
// with sticky error flags and a once-per-burst input-arrival interrupt.
module io_port_unit
  import io_port_unit_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 4,
  parameter int INT_EN    = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] cpu_out,
  input  logic              cpu_out_we,
  output logic              out_full,
  output logic [DATA_W-1:0] cpu_in,
  input  logic              cpu_in_rd,
  output logic              in_empty,
  output logic              cpu_int,
  output logic [DATA_W-1:0] dev_out_data,
  output logic              dev_out_valid,
  input  logic              dev_out_ready,
  input  logic [DATA_W-1:0] dev_in_data,
  input  logic              dev_in_valid,
  output logic              dev_in_ready,
  output logic [1:0]        err_flags
);

  localparam int   OUT_AW   = $clog2(OUT_DEPTH);
  localparam int   IN_AW    = $clog2(IN_DEPTH);
  localparam logic L_INT_ON = (INT_EN != 0);

  logic              w_out_push;
  logic              w_out_pop;
  logic              w_out_full;
  logic              w_out_empty;
  logic [DATA_W-1:0] w_out_head;
  logic [OUT_AW:0]   w_out_count;
  logic              w_out_ovf;

  logic              w_in_push;
  logic              w_in_pop;
  logic              w_in_full;
  logic              w_in_empty;
  logic [DATA_W-1:0] w_in_head;
  logic [IN_AW:0]    w_in_count;
  logic [IN_AW:0]    w_in_cnt_nxt;
  logic              w_in_unf;

  logic [1:0]        r_err;
  int_state_t        r_int_state;
  logic              r_cpu_int;

  assign w_out_pop  = dev_out_ready && (w_out_count != '0);
  assign w_out_push = cpu_out_we && (!w_out_full || w_out_pop);
  assign w_out_ovf  = cpu_out_we && !w_out_push;

  assign w_in_push  = dev_in_valid && !w_in_full;
  assign w_in_pop   = cpu_in_rd && !w_in_empty;
  assign w_in_unf   = cpu_in_rd && w_in_empty;

  sync_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (w_out_push),
    .pop   (w_out_pop),
    .din   (cpu_out),
    .dout  (w_out_head),
    .full  (w_out_full),
    .empty (w_out_empty),
    .count (w_out_count)
  );

  sync_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (w_in_push),
    .pop   (w_in_pop),
    .din   (dev_in_data),
    .dout  (w_in_head),
    .full  (w_in_full),
    .empty (w_in_empty),
    .count (w_in_count)
  );

  // The FSM looks at the post-edge occupancy so an empty+refill cycle never re-arms.
  always_comb begin
    w_in_cnt_nxt = w_in_count;
    case ({w_in_push, w_in_pop})
      2'b10:   w_in_cnt_nxt = w_in_count + (IN_AW+1)'(1);
      2'b01:   w_in_cnt_nxt = w_in_count - (IN_AW+1)'(1);
      default: w_in_cnt_nxt = w_in_count;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_err <= 2'b00;
    end else begin
      if (w_out_ovf) begin
        r_err[ERR_OUT_OVF] <= 1'b1;
      end
      if (w_in_unf) begin
        r_err[ERR_IN_UNF] <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_int_state <= ST_IDLE;
      r_cpu_int   <= 1'b0;
    end else begin
      case (r_int_state)
        ST_IDLE: begin
          if (w_in_cnt_nxt != '0) begin
            r_int_state <= ST_PULSE;
            r_cpu_int   <= L_INT_ON;
          end else begin
            r_int_state <= ST_IDLE;
            r_cpu_int   <= 1'b0;
          end
        end
        ST_PULSE: begin
          r_int_state <= ST_ARMED_WAIT;
          r_cpu_int   <= 1'b0;
        end
        ST_ARMED_WAIT: begin
          if (w_in_cnt_nxt == '0) begin
            r_int_state <= ST_IDLE;
          end else begin
            r_int_state <= ST_ARMED_WAIT;
          end
          r_cpu_int <= 1'b0;
        end
        default: begin
          r_int_state <= ST_IDLE;
          r_cpu_int   <= 1'b0;
        end
      endcase
    end
  end

  assign out_full      = w_out_full;
  assign dev_out_valid = !w_out_empty;
  assign dev_out_data  = w_out_head;
  assign in_empty      = w_in_empty;
  assign dev_in_ready  = !w_in_full;
  assign cpu_in        = w_in_empty ? '0 : w_in_head;
  assign cpu_int       = r_cpu_int;
  assign err_flags     = r_err;

endmodule
